// File: rtl/parking_spot_allocator_pkg.sv
// Shared constants for the parking spot allocator:
// spot count, index widths, gate timing and entry FSM encodings.
package parking_spot_allocator_pkg;

    localparam int N_SPOTS     = 8;
    localparam int GATE_CYCLES = 4;
    localparam int SPOT_W      = 3;
    localparam int CNT_W       = SPOT_W + 1;
    localparam int GCNT_W      =
        (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [1:0] E_IDLE = 2'd0;
    localparam logic [1:0] E_GATE = 2'd1;
    localparam logic [1:0] E_WAIT = 2'd2;

endpackage

// File: rtl/parking_spot_allocator_if.sv
// Gate-side bus of the allocator.
// master: sensors/bench (drive requests); slave: allocator.
interface parking_spot_allocator_if;
    import parking_spot_allocator_pkg::*;

    logic              entry_req;
    logic              entry_ack;
    logic [SPOT_W-1:0] entry_spot;
    logic              entry_full;
    logic              gate_open;
    logic              exit_req;
    logic [SPOT_W-1:0] exit_spot;
    logic              exit_ack;
    logic              exit_err;
    logic [N_SPOTS-1:0] spot_vec;
    logic [CNT_W-1:0]  free_cnt;

    modport master (
        output entry_req, exit_req, exit_spot,
        input  entry_ack, entry_spot, entry_full,
        input  gate_open, exit_ack, exit_err,
        input  spot_vec, free_cnt
    );

    modport slave (
        input  entry_req, exit_req, exit_spot,
        output entry_ack, entry_spot, entry_full,
        output gate_open, exit_ack, exit_err,
        output spot_vec, free_cnt
    );

endinterface

// File: rtl/parking_spot_allocator_lowest_free_encoder.sv
// Combinational priority encoder: index of lowest set bit.
// Ports: vec_i (1=free), idx_o (lowest free), any_free_o.
module lowest_free_encoder
    import parking_spot_allocator_pkg::*;
(
    input  logic [N_SPOTS-1:0] vec_i,
    output logic [SPOT_W-1:0]  idx_o,
    output logic               any_free_o
);

    // Scan downwards so the last hit is the lowest index.
    always_comb begin
        idx_o      = '0;
        any_free_o = 1'b0;
        for (int i = N_SPOTS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o      = SPOT_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_spot_allocator.sv
// Owns the spot occupancy vector; grants lowest free spot
// on entry, releases spots on exit, drives the entry gate.
// Ports: clk, rst_n (sync, active low), bus (slave modport).
module parking_spot_allocator
    import parking_spot_allocator_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    parking_spot_allocator_if.slave bus
);

    logic [1:0]         state_q, state_d;
    logic [GCNT_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic               gate_open_q, gate_open_d;
    logic [N_SPOTS-1:0] spot_vec_q, spot_vec_d;
    logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
    logic [SPOT_W-1:0]  entry_spot_q, entry_spot_d;
    logic               entry_ack_q, entry_full_q;
    logic               exit_ack_q, exit_err_q;

    logic [SPOT_W-1:0]  low_idx;
    logic               any_free;
    logic               grant, reject;
    logic               exit_in_range, exit_ok;

    lowest_free_encoder u_enc (
        .vec_i      (spot_vec_q),
        .idx_o      (low_idx),
        .any_free_o (any_free)
    );

    assign grant  = (state_q == E_IDLE) & bus.entry_req
                  & any_free;
    assign reject = (state_q == E_IDLE) & bus.entry_req
                  & ~any_free;

    assign exit_in_range =
        ({1'b0, bus.exit_spot} < CNT_W'(N_SPOTS));
    // Only an occupied, existing spot can be released.
    assign exit_ok = bus.exit_req & exit_in_range
                   & ~spot_vec_q[bus.exit_spot];

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        gate_open_d  = gate_open_q;
        entry_spot_d = entry_spot_q;
        case (state_q)
            E_IDLE: begin
                if (grant) begin
                    state_d      = E_GATE;
                    gate_cnt_d   = GCNT_W'(GATE_CYCLES - 1);
                    gate_open_d  = 1'b1;
                    entry_spot_d = low_idx;
                end else if (reject) begin
                    state_d = E_WAIT;
                end
            end
            E_GATE: begin
                if (gate_cnt_q == '0) begin
                    gate_open_d = 1'b0;
                    state_d     = E_WAIT;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            E_WAIT: begin
                if (!bus.entry_req) begin
                    state_d = E_IDLE;
                end
            end
            default: begin
                state_d     = E_IDLE;
                gate_open_d = 1'b0;
            end
        endcase
    end

    // Grant picks from the pre-exit vector; the two bit
    // updates never touch the same spot (free vs occupied).
    always_comb begin
        spot_vec_d = spot_vec_q;
        if (grant) begin
            spot_vec_d[low_idx] = 1'b0;
        end
        if (exit_ok) begin
            spot_vec_d[bus.exit_spot] = 1'b1;
        end
    end

    always_comb begin
        free_cnt_d = free_cnt_q;
        unique case (1'b1)
            grant & ~exit_ok: free_cnt_d = free_cnt_q - 1'b1;
            exit_ok & ~grant: free_cnt_d = free_cnt_q + 1'b1;
            default:          free_cnt_d = free_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= E_IDLE;
            gate_cnt_q   <= '0;
            gate_open_q  <= 1'b0;
            spot_vec_q   <= '1;
            free_cnt_q   <= CNT_W'(N_SPOTS);
            entry_spot_q <= '0;
            entry_ack_q  <= 1'b0;
            entry_full_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            gate_open_q  <= gate_open_d;
            spot_vec_q   <= spot_vec_d;
            free_cnt_q   <= free_cnt_d;
            entry_spot_q <= entry_spot_d;
            entry_ack_q  <= grant;
            entry_full_q <= reject;
            exit_ack_q   <= exit_ok;
            exit_err_q   <= bus.exit_req & ~exit_ok;
        end
    end

    assign bus.entry_ack  = entry_ack_q;
    assign bus.entry_spot = entry_spot_q;
    assign bus.entry_full = entry_full_q;
    assign bus.gate_open  = gate_open_q;
    assign bus.exit_ack   = exit_ack_q;
    assign bus.exit_err   = exit_err_q;
    assign bus.spot_vec   = spot_vec_q;
    assign bus.free_cnt   = free_cnt_q;

endmodule
